// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle, followed by a sign-fixup/write cycle.
module mips_muldiv #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic [width-1:0] md_a,
    input  logic [width-1:0] md_b,
    input  logic             md_abort,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [width-1:0] md_wdata,
    output logic             md_busy,
    output logic             md_done,
    output logic             md_div0,
    output logic [width-1:0] hi,
    output logic [width-1:0] lo
);

    localparam int CW = $clog2(width) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t               state, state_nxt;
    logic [2*width-1:0]   acc;
    logic [width-1:0]     opb;
    logic [CW-1:0]        cnt;
    logic                 neg_res, neg_rem, is_div, b_zero;

    logic                 accept, last, a_neg, b_neg;
    logic [width-1:0]     upper, quo, rem;
    logic [width:0]       mul_sum, rem_sh, diff;
    logic [2*width-1:0]   prod;

    function automatic logic [width-1:0] neg_w(input logic [width-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*width-1:0] neg_2w(input logic [2*width-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    assign accept  = (state == S_IDLE) && md_start && !md_abort;
    assign last    = (cnt == CW'(width - 1));
    assign a_neg   = !md_op[0] && md_a[width-1];
    assign b_neg   = !md_op[0] && md_b[width-1];
    assign upper   = acc[2*width-1:width];

    // Multiply step: add multiplicand into the upper half when the LSB is set, shift right.
    assign mul_sum = {1'b0, upper} + (acc[0] ? {1'b0, opb} : '0);
    // Divide step: shift remainder left one bit; the borrow out decides restore vs keep.
    assign rem_sh  = {upper, acc[width-1]};
    assign diff    = rem_sh - {1'b0, opb};

    assign prod    = neg_2w(acc, neg_res);
    assign quo     = b_zero ? '1 : neg_w(acc[width-1:0], neg_res);
    assign rem     = neg_w(upper, neg_rem);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = md_op[1] ? S_DIV : S_MUL;
            S_MUL, S_DIV: begin
                if (md_abort)  state_nxt = S_IDLE;
                else if (last) state_nxt = S_FIX;
            end
            S_FIX:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            acc     <= '0;
            opb     <= '0;
            cnt     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            is_div  <= 1'b0;
            b_zero  <= 1'b0;
            md_busy <= 1'b0;
            md_done <= 1'b0;
            md_div0 <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            md_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hi_we) hi <= md_wdata;
                    if (lo_we) lo <= md_wdata;
                    if (accept) begin
                        acc     <= {{width{1'b0}}, neg_w(md_a, a_neg)};
                        opb     <= neg_w(md_b, b_neg);
                        cnt     <= '0;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        is_div  <= md_op[1];
                        b_zero  <= (md_b == '0);
                        md_busy <= 1'b1;
                        md_div0 <= 1'b0;
                    end
                end
                S_MUL: begin
                    if (md_abort) begin
                        md_busy <= 1'b0;
                    end else begin
                        acc <= {mul_sum, acc[width-1:1]};
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    if (md_abort) begin
                        md_busy <= 1'b0;
                    end else begin
                        if (!diff[width]) acc <= {diff[width-1:0], acc[width-2:0], 1'b1};
                        else              acc <= {rem_sh[width-1:0], acc[width-2:0], 1'b0};
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    md_busy <= 1'b0;
                    if (!md_abort) begin
                        // Divide-by-zero keeps HI = dividend: the restoring loop leaves |a| there
                        // and the remainder sign fixup restores the original a.
                        if (is_div) begin
                            hi <= rem;
                            lo <= quo;
                        end else begin
                            hi <= prod[2*width-1:width];
                            lo <= prod[width-1:0];
                        end
                        md_done <= 1'b1;
                        md_div0 <= is_div && b_zero;
                    end
                end
                default: md_busy <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv: width=32 and width=8 instances against an arithmetic model.
module tb_mips_muldiv;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t q32[$];
    exp_t q8[$];

    logic        a_start = 0, a_abort = 0, a_hwe = 0, a_lwe = 0;
    logic [1:0]  a_op = 0;
    logic [31:0] a_a = 0, a_b = 0, a_wd = 0;
    logic        a_busy, a_done, a_div0;
    logic [31:0] a_hi, a_lo;

    logic        b_start = 0, b_abort = 0, b_hwe = 0, b_lwe = 0;
    logic [1:0]  b_op = 0;
    logic [7:0]  b_a = 0, b_b = 0, b_wd = 0;
    logic        b_busy, b_done, b_div0;
    logic [7:0]  b_hi, b_lo;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mips_muldiv #(.width(32)) dut32 (
        .clk(clk), .rst_b(rst_b), .md_start(a_start), .md_op(a_op), .md_a(a_a), .md_b(a_b),
        .md_abort(a_abort), .hi_we(a_hwe), .lo_we(a_lwe), .md_wdata(a_wd),
        .md_busy(a_busy), .md_done(a_done), .md_div0(a_div0), .hi(a_hi), .lo(a_lo)
    );

    mips_muldiv #(.width(8)) dut8 (
        .clk(clk), .rst_b(rst_b), .md_start(b_start), .md_op(b_op), .md_a(b_a), .md_b(b_b),
        .md_abort(b_abort), .hi_we(b_hwe), .lo_we(b_lwe), .md_wdata(b_wd),
        .md_busy(b_busy), .md_done(b_done), .md_div0(b_div0), .hi(b_hi), .lo(b_lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on w-bit operands.
    function automatic exp_t model(input int w, input logic [1:0] op,
                                   input logic [31:0] a, input logic [31:0] b, input int dc);
        exp_t e;
        longint unsigned mask, ua, ub, pu;
        longint sa, sb, p, q, r, minv;
        logic [63:0] t;
        logic [31:0] m32;
        mask = (64'd1 << w) - 64'd1;
        m32  = mask[31:0];
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb   = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        minv = -(longint'(1) << (w - 1));
        e.div0 = 1'b0;
        e.cyc  = dc;
        e.hi   = '0;
        e.lo   = '0;
        q = 0;
        r = 0;
        case (op)
            2'b00: begin
                p = sa * sb;
                t = p >>> w;  e.hi = t[31:0] & m32;
                t = p;        e.lo = t[31:0] & m32;
            end
            2'b01: begin
                pu = ua * ub;
                t = pu >> w;  e.hi = t[31:0] & m32;
                t = pu;       e.lo = t[31:0] & m32;
            end
            default: begin
                if (ub == 0) begin
                    e.lo = m32;
                    e.hi = ua[31:0];
                    e.div0 = 1'b1;
                end else begin
                    if (op == 2'b10 && sa == minv && sb == -1) begin
                        q = minv;
                        r = 0;
                    end else if (op == 2'b10) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = longint'(ua / ub);
                        r = longint'(ua % ub);
                    end
                    t = q; e.lo = t[31:0] & m32;
                    t = r; e.hi = t[31:0] & m32;
                end
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rnd(input int w);
        logic [31:0] v, m;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 5))
            0: v = 32'd0;
            1: v = 32'd1 << (w - 1);
            2: v = 32'hFFFF_FFFF;
            3: v = 32'd1;
            default: v = $urandom;
        endcase
        return v & m;
    endfunction

    // Monitor: every md_done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_b && a_done) begin
            if (q32.size() == 0) begin
                chk("w32_unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q32.pop_front();
                chk("w32_hi", a_hi, e.hi);
                chk("w32_lo", a_lo, e.lo);
                chk("w32_div0", a_div0, e.div0);
                chk("w32_done_cycle", cyc, e.cyc);
                chk("w32_busy_at_done", a_busy, 0);
            end
        end
        if (rst_b && b_done) begin
            if (q8.size() == 0) begin
                chk("w8_unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("w8_hi", b_hi, e.hi[7:0]);
                chk("w8_lo", b_lo, e.lo[7:0]);
                chk("w8_div0", b_div0, e.div0);
                chk("w8_done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic start32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        a_start = 1; a_op = op; a_a = a; a_b = b;
        @(posedge clk); #1;
        a_start = 0;
        q32.push_back(model(32, op, a, b, cyc + 33));
    endtask

    task automatic start8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        b_start = 1; b_op = op; b_a = a; b_b = b;
        @(posedge clk); #1;
        b_start = 0;
        q8.push_back(model(8, op, {24'd0, a}, {24'd0, b}, cyc + 9));
    endtask

    task automatic wait_done32;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (a_done) return;
        end
        chk("w32_done_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_done8;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (b_done) return;
        end
        chk("w8_done_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        logic [31:0] keep_hi, keep_lo;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs32", {a_busy, a_done, a_div0, a_hi, a_lo}, '0);
        chk("rst_outputs8", {b_busy, b_done, b_div0, b_hi, b_lo}, '0);
        rst_b = 1;
        @(posedge clk); #1;

        // Directed width=32 cases
        start32(2'b00, 32'hFFFF_FFFD, 32'd5);
        chk("busy_after_start", a_busy, 1);
        wait_done32();
        start32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done32();
        start32(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done32();
        start32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done32();
        start32(2'b11, 32'd7, 32'd0);
        wait_done32();
        chk("div0_held", a_div0, 1);
        start32(2'b01, 32'd3, 32'd4);
        chk("div0_cleared_on_start", a_div0, 0);

        // Second start while busy must be ignored
        repeat (5) @(posedge clk);
        #1;
        a_start = 1; a_op = 2'b00; a_a = 32'd99; a_b = 32'd77;
        @(posedge clk); #1;
        a_start = 0;
        wait_done32();
        keep_hi = 32'd0;
        keep_lo = 32'd12;

        // Abort at cycle 10 of a MULTU: back to idle, HI/LO retained
        start32(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        void'(q32.pop_back());
        repeat (9) @(posedge clk);
        #1;
        a_abort = 1;
        @(posedge clk); #1;
        a_abort = 0;
        chk("abort_busy", a_busy, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_hi_kept", a_hi, keep_hi);
        chk("abort_lo_kept", a_lo, keep_lo);

        // Abort together with start in idle drops the start
        a_start = 1; a_abort = 1; a_op = 2'b01; a_a = 32'd5; a_b = 32'd5;
        @(posedge clk); #1;
        a_start = 0; a_abort = 0;
        chk("abort_start_dropped", a_busy, 0);

        // MTHI in idle, MTLO with start on the same edge, MTLO while busy ignored
        a_hwe = 1; a_wd = 32'hCAFE_0001;
        @(posedge clk); #1;
        a_hwe = 0;
        chk("mthi_idle", a_hi, 32'hCAFE_0001);
        a_lwe = 1; a_wd = 32'hBEEF_0002;
        start32(2'b10, 32'd100, 32'd7);
        a_lwe = 0;
        chk("mtlo_with_start", a_lo, 32'hBEEF_0002);
        a_lwe = 1; a_wd = 32'h0000_0BAD;
        @(posedge clk); #1;
        a_lwe = 0;
        chk("mtlo_busy_ignored", a_lo, 32'hBEEF_0002);
        wait_done32();

        // Randomized back-to-back operations (each start issued in the done cycle)
        for (int i = 0; i < 40; i++) begin
            start32(2'($urandom_range(0, 3)), rnd(32), rnd(32));
            wait_done32();
        end

        // Reset mid-operation clears everything and produces no done
        start32(2'b00, 32'h0000_1234, 32'h0000_5678);
        repeat (6) @(posedge clk);
        #1;
        rst_b = 0;
        q32.delete();
        @(posedge clk); #1;
        chk("midop_reset32", {a_busy, a_done, a_div0, a_hi, a_lo}, '0);
        rst_b = 1;
        @(posedge clk); #1;

        // width=8 instance
        start8(2'b00, 8'h80, 8'h80);
        wait_done8();
        b_lwe = 1; b_wd = 8'h5A;
        @(posedge clk); #1;
        b_lwe = 0;
        chk("w8_mtlo", b_lo, 8'h5A);
        for (int i = 0; i < 30; i++) begin
            start8(2'($urandom_range(0, 3)), 8'(rnd(8)), 8'(rnd(8)));
            wait_done8();
        end

        repeat (5) @(posedge clk);
        #1;
        chk("q32_drained", q32.size(), 0);
        chk("q8_drained", q8.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
